// File: rtl/spi_resp_pkg.sv
// Shared types and constants for the SPI memory responder.
package spi_resp_pkg;
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, IGNORE} state_t;

  localparam logic [7:0] OPC_READ  = 8'h03;
  localparam logic [7:0] OPC_WRITE = 8'h02;
  localparam int         CMD_BITS  = 8;
  localparam int         ADDR_BITS = 16;
  localparam int         DATA_BITS = 16;
endpackage

// File: rtl/spi_resp_sync.sv
// Two-flop synchronizers for the SPI pins plus edge detection on the synchronized copies.
// Left unreset so a held-low cs_n across rst produces no false falling edge.
module spi_resp_sync (
  input  logic clk,
  input  logic cs_n,
  input  logic sclk,
  input  logic mosi,
  output logic mosi_s,
  output logic sclk_rise,
  output logic sclk_fall,
  output logic cs_fall,
  output logic cs_rise
);
  logic [1:0] cs_ff;
  logic [1:0] sclk_ff;
  logic [1:0] mosi_ff;
  logic       cs_d;
  logic       sclk_d;

  always_ff @(posedge clk) begin
    cs_ff   <= {cs_ff[0], cs_n};
    sclk_ff <= {sclk_ff[0], sclk};
    mosi_ff <= {mosi_ff[0], mosi};
    cs_d    <= cs_ff[1];
    sclk_d  <= sclk_ff[1];
  end

  assign mosi_s    = mosi_ff[1];
  assign sclk_rise = sclk_ff[1] & ~sclk_d;
  assign sclk_fall = ~sclk_ff[1] & sclk_d;
  assign cs_fall   = ~cs_ff[1] & cs_d;
  assign cs_rise   = cs_ff[1] & ~cs_d;
endmodule

// File: rtl/spi_mem_responder.sv
// SPI mode-0 responder bridging read (0x03) / write (0x02) commands to a 16-bit word store.
// Define SPI_RESP_AUTOINC_EN to keep streaming words at successive addresses.
module spi_mem_responder
  import spi_resp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_n,
  input  logic        sclk,
  input  logic        mosi,
  output logic        miso,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_rdata,
  output logic        mem_wr,
  output logic [15:0] mem_wdata
);
  state_t                 state;
  logic [4:0]             cnt;
  logic [CMD_BITS-2:0]    cmd_sr;
  logic [ADDR_BITS-2:0]   addr_sr;
  logic [DATA_BITS-2:0]   data_sr;
  logic [DATA_BITS-1:0]   tx_sr;
  logic                   is_rd;
  logic                   ld_p1;
  logic                   mosi_s, sclk_rise, sclk_fall, cs_fall, cs_rise;
  logic [7:0]             opc;

  spi_resp_sync u_sync (
    .clk       (clk),
    .cs_n      (cs_n),
    .sclk      (sclk),
    .mosi      (mosi),
    .mosi_s    (mosi_s),
    .sclk_rise (sclk_rise),
    .sclk_fall (sclk_fall),
    .cs_fall   (cs_fall),
    .cs_rise   (cs_rise)
  );

  assign opc = {cmd_sr, mosi_s};

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cmd_sr    <= '0;
      addr_sr   <= '0;
      data_sr   <= '0;
      tx_sr     <= '0;
      is_rd     <= 1'b0;
      ld_p1     <= 1'b0;
      miso      <= 1'b0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_rd <= 1'b0;
      mem_wr <= 1'b0;
      // Read data arrives the clk after the strobe; ld_p1 marks that clk.
      ld_p1  <= mem_rd;
`ifdef SPI_RESP_AUTOINC_EN
      if (mem_wr) mem_addr <= mem_addr + 16'd1;
`endif
      if (cs_rise) begin
        state <= IDLE;
        cnt   <= '0;
        miso  <= 1'b0;
      end else if (cs_fall) begin
        state <= CMD;
        cnt   <= '0;
        miso  <= 1'b0;
      end else begin
        case (state)
          IDLE: ;
          CMD: if (sclk_rise) begin
            cmd_sr <= opc[CMD_BITS-2:0];
            if (cnt == 5'(CMD_BITS - 1)) begin
              cnt <= '0;
              if (opc == OPC_READ) begin
                is_rd <= 1'b1;
                state <= ADDR;
              end else if (opc == OPC_WRITE) begin
                is_rd <= 1'b0;
                state <= ADDR;
              end else begin
                state <= IGNORE;
              end
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          ADDR: if (sclk_rise) begin
            addr_sr <= {mosi_s, addr_sr[ADDR_BITS-2:1]};
            if (cnt == 5'(ADDR_BITS - 1)) begin
              mem_addr <= {mosi_s, addr_sr};
              mem_rd   <= is_rd;
              state    <= DATA;
              cnt      <= '0;
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          DATA: if (is_rd) begin
            // Shift out on the fall, count on the rise so the last bit stays valid until sampled.
            if (sclk_fall) begin
              miso  <= tx_sr[0];
              tx_sr <= {1'b0, tx_sr[DATA_BITS-1:1]};
            end
            if (sclk_rise) begin
              if (cnt == 5'(DATA_BITS - 1)) begin
                cnt <= '0;
`ifdef SPI_RESP_AUTOINC_EN
                mem_addr <= mem_addr + 16'd1;
                mem_rd   <= 1'b1;
`else
                state <= IGNORE;
                miso  <= 1'b0;
`endif
              end else begin
                cnt <= cnt + 5'd1;
              end
            end
          end else if (sclk_rise) begin
            data_sr <= {mosi_s, data_sr[DATA_BITS-2:1]};
            if (cnt == 5'(DATA_BITS - 1)) begin
              mem_wr    <= 1'b1;
              mem_wdata <= {mosi_s, data_sr};
              cnt       <= '0;
`ifndef SPI_RESP_AUTOINC_EN
              state <= IGNORE;
`endif
            end else begin
              cnt <= cnt + 5'd1;
            end
          end
          IGNORE: miso <= 1'b0;
          default: state <= IDLE;
        endcase
      end
      if (ld_p1) tx_sr <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_spi_mem_responder.sv
// Randomized bench for spi_mem_responder with a word-level memory and transaction model.
module tb_spi_mem_responder;
  import spi_resp_pkg::*;

  localparam int H = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_n = 1'b1;
  logic        sclk = 1'b0;
  logic        mosi = 1'b0;
  logic        miso;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic [15:0] mem_rdata;
  logic        mem_wr;
  logic [15:0] mem_wdata;

  int checks = 0;
  int failures = 0;

  logic [15:0] mem [65536];
  logic [15:0] rd_q [$];
  logic [31:0] wr_q [$];
  int          overlap = 0;
  logic        rd_pend = 1'b0;
  logic [15:0] pend_addr = '0;

  spi_mem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .cs_n      (cs_n),
    .sclk      (sclk),
    .mosi      (mosi),
    .miso      (miso),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_rdata (mem_rdata),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata)
  );

  always #5 clk = ~clk;

  // Backing store: rdata is meaningful only in the clk after a strobe, garbage otherwise.
  always @(negedge clk) begin
    if (rd_pend) mem_rdata = mem[pend_addr];
    else mem_rdata = 16'($urandom);
    rd_pend   = mem_rd;
    pend_addr = mem_addr;
    if (mem_rd) rd_q.push_back(mem_addr);
    if (mem_wr) wr_q.push_back({mem_addr, mem_wdata});
    if (mem_rd && mem_wr) overlap++;
  end

  task automatic clear_mon();
    rd_q.delete();
    wr_q.delete();
    overlap = 0;
  endtask

  task automatic spi_bit(input logic b, output logic s);
    mosi = b;
    repeat (H) @(posedge clk);
    #1 s = miso;
    sclk = 1'b1;
    repeat (H) @(posedge clk);
    #1 sclk = 1'b0;
  endtask

  task automatic cs_start();
    @(posedge clk);
    #1 cs_n = 1'b0;
    repeat (H) @(posedge clk);
    #1;
  endtask

  task automatic cs_stop();
    repeat (H) @(posedge clk);
    #1 cs_n = 1'b1;
    repeat (2 * H) @(posedge clk);
    #1;
  endtask

  task automatic txn(input logic [7:0] opc, input logic [15:0] addr, input int nbits,
                     input logic [31:0] wdata, output logic [31:0] rbits, output logic pre);
    logic s;
    pre = 1'b0;
    rbits = '0;
    cs_start();
    for (int i = 7; i >= 0; i--) begin spi_bit(opc[i], s); pre |= s; end
    for (int i = 0; i < 16; i++) begin spi_bit(addr[i], s); pre |= s; end
    for (int i = 0; i < nbits; i++) begin spi_bit(wdata[i], s); rbits[i] = s; end
    cs_stop();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (miso !== 1'b0) begin failures++; $display("FAIL reset_miso got=%b exp=0", miso); end
    checks++; if (mem_rd !== 1'b0) begin failures++; $display("FAIL reset_mem_rd got=%b exp=0", mem_rd); end
    checks++; if (mem_wr !== 1'b0) begin failures++; $display("FAIL reset_mem_wr got=%b exp=0", mem_wr); end
    checks++; if (mem_addr !== 16'h0) begin failures++; $display("FAIL reset_mem_addr got=%h exp=0000", mem_addr); end
    checks++; if (mem_wdata !== 16'h0) begin failures++; $display("FAIL reset_mem_wdata got=%h exp=0000", mem_wdata); end
    checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dut.state, IDLE); end
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_read();
    logic [31:0] rb;
    logic pre;
    mem[16'h1234] = 16'hBEEF;
    clear_mon();
    txn(OPC_READ, 16'h1234, 16, 32'h0, rb, pre);
    checks++; if (rd_q.size() !== 1) begin failures++; $display("FAIL read_rd_count got=%0d exp=1", rd_q.size()); end
    else begin checks++; if (rd_q[0] !== 16'h1234) begin failures++; $display("FAIL read_rd_addr got=%h exp=1234", rd_q[0]); end end
    checks++; if (mem_addr !== 16'h1234) begin failures++; $display("FAIL read_mem_addr got=%h exp=1234", mem_addr); end
    checks++; if (rb[15:0] !== 16'hBEEF) begin failures++; $display("FAIL read_miso_seq got=%h exp=beef", rb[15:0]); end
    checks++; if (pre !== 1'b0) begin failures++; $display("FAIL read_miso_pre got=%b exp=0", pre); end
    checks++; if (wr_q.size() !== 0) begin failures++; $display("FAIL read_no_wr got=%0d exp=0", wr_q.size()); end
    checks++; if (miso !== 1'b0) begin failures++; $display("FAIL read_miso_idle got=%b exp=0", miso); end
  endtask

  task automatic test_write();
    logic [31:0] rb;
    logic pre;
    clear_mon();
    txn(OPC_WRITE, 16'h0042, 16, 32'h0000A5C3, rb, pre);
    mem[16'h0042] = 16'hA5C3;
    checks++; if (wr_q.size() !== 1) begin failures++; $display("FAIL write_wr_count got=%0d exp=1", wr_q.size()); end
    else begin checks++; if (wr_q[0] !== 32'h0042A5C3) begin failures++; $display("FAIL write_word got=%h exp=0042a5c3", wr_q[0]); end end
    checks++; if (rd_q.size() !== 0) begin failures++; $display("FAIL write_no_rd got=%0d exp=0", rd_q.size()); end
    checks++; if ((rb | {31'h0, pre}) !== 32'h0) begin failures++; $display("FAIL write_miso got=%h exp=0", rb); end
  endtask

  task automatic test_bad_opcode();
    logic [31:0] rb;
    logic pre;
    clear_mon();
    txn(8'h05, 16'(mem_addr + 16'd3), 16, $urandom, rb, pre);
    checks++; if (rd_q.size() + wr_q.size() !== 0) begin failures++; $display("FAIL badopc_strobes got=%0d exp=0", rd_q.size() + wr_q.size()); end
    checks++; if ((rb | {31'h0, pre}) !== 32'h0) begin failures++; $display("FAIL badopc_miso got=%h exp=0", rb); end
  endtask

  task automatic test_abort();
    logic [31:0] rb;
    logic pre;
    logic [15:0] a, d;
    clear_mon();
    txn(OPC_WRITE, 16'h0007, 10, $urandom, rb, pre);
    checks++; if (wr_q.size() !== 0) begin failures++; $display("FAIL abort_no_wr got=%0d exp=0", wr_q.size()); end
    a = 16'($urandom);
    d = 16'($urandom);
    clear_mon();
    txn(OPC_WRITE, a, 16, {16'h0, d}, rb, pre);
    mem[a] = d;
    checks++; if (wr_q.size() !== 1) begin failures++; $display("FAIL abort_next_count got=%0d exp=1", wr_q.size()); end
    else begin checks++; if (wr_q[0] !== {a, d}) begin failures++; $display("FAIL abort_next_word got=%h exp=%h", wr_q[0], {a, d}); end end
    clear_mon();
    txn(OPC_READ, 16'h0007, 16, 32'h0, rb, pre);
    checks++; if (rb[15:0] !== mem[16'h0007]) begin failures++; $display("FAIL abort_mem_kept got=%h exp=%h", rb[15:0], mem[16'h0007]); end
  endtask

  task automatic test_random();
    logic [31:0] rb;
    logic pre;
    logic [15:0] a, d;
    for (int n = 0; n < 10; n++) begin
      a = (n % 3 == 2) ? 16'h0042 : 16'($urandom);
      d = 16'($urandom);
      clear_mon();
      if ($urandom_range(1, 0) == 1) begin
        txn(OPC_WRITE, a, 16, {16'h0, d}, rb, pre);
        mem[a] = d;
        checks++; if (wr_q.size() !== 1 || rd_q.size() !== 0) begin failures++; $display("FAIL rand_wr_count got=%0d exp=1", wr_q.size()); end
        else begin checks++; if (wr_q[0] !== {a, d}) begin failures++; $display("FAIL rand_wr_word got=%h exp=%h", wr_q[0], {a, d}); end end
      end else begin
        txn(OPC_READ, a, 16, 32'h0, rb, pre);
        checks++; if (rd_q.size() !== 1 || wr_q.size() !== 0) begin failures++; $display("FAIL rand_rd_count got=%0d exp=1", rd_q.size()); end
        checks++; if (rb[15:0] !== mem[a] || pre !== 1'b0) begin failures++; $display("FAIL rand_rd_data addr=%h got=%h exp=%h", a, rb[15:0], mem[a]); end
      end
      checks++; if (overlap !== 0) begin failures++; $display("FAIL rand_overlap got=%0d exp=0", overlap); end
    end
  endtask

  task automatic test_reset_mid();
    logic s;
    logic [31:0] rb;
    logic pre;
    logic [15:0] ra;
    clear_mon();
    ra = 16'h1234;
    cs_start();
    for (int i = 7; i >= 0; i--) spi_bit(OPC_READ[i], s);
    for (int i = 0; i < 9; i++) spi_bit(ra[i], s);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({miso, mem_rd, mem_wr, mem_addr, mem_wdata} !== 35'h0) begin failures++; $display("FAIL rstmid_outputs got=%h exp=0", {miso, mem_rd, mem_wr, mem_addr, mem_wdata}); end
    for (int i = 0; i < 12; i++) spi_bit(1'b1, s);
    checks++; if (dut.state !== IDLE) begin failures++; $display("FAIL rstmid_state got=%0d exp=%0d", dut.state, IDLE); end
    checks++; if (rd_q.size() + wr_q.size() !== 0) begin failures++; $display("FAIL rstmid_strobes got=%0d exp=0", rd_q.size() + wr_q.size()); end
    cs_stop();
    clear_mon();
    txn(OPC_READ, 16'h0001, 16, 32'h0, rb, pre);
    checks++; if (rd_q.size() !== 1) begin failures++; $display("FAIL rstmid_next_count got=%0d exp=1", rd_q.size()); end
    checks++; if (rb[15:0] !== mem[16'h0001] || mem_addr !== 16'h0001) begin failures++; $display("FAIL rstmid_next_data got=%h exp=%h", rb[15:0], mem[16'h0001]); end
  endtask

`ifdef SPI_RESP_AUTOINC_EN
  task automatic test_autoinc();
    logic [31:0] rb;
    logic pre;
    logic [15:0] d0, d1;
    clear_mon();
    txn(OPC_READ, 16'hFFFF, 32, 32'h0, rb, pre);
    checks++; if (rd_q.size() < 2) begin failures++; $display("FAIL autoinc_rd_count got=%0d exp=2", rd_q.size()); end
    else begin checks++; if (rd_q[0] !== 16'hFFFF || rd_q[1] !== 16'h0000) begin failures++; $display("FAIL autoinc_rd_addr got=%h,%h exp=ffff,0000", rd_q[0], rd_q[1]); end end
    checks++; if (rb !== {mem[16'h0000], mem[16'hFFFF]}) begin failures++; $display("FAIL autoinc_miso got=%h exp=%h", rb, {mem[16'h0000], mem[16'hFFFF]}); end
    d0 = 16'($urandom);
    d1 = 16'($urandom);
    clear_mon();
    txn(OPC_WRITE, 16'h0100, 32, {d1, d0}, rb, pre);
    mem[16'h0100] = d0;
    mem[16'h0101] = d1;
    checks++; if (wr_q.size() !== 2) begin failures++; $display("FAIL autoinc_wr_count got=%0d exp=2", wr_q.size()); end
    else begin checks++; if (wr_q[0] !== {16'h0100, d0} || wr_q[1] !== {16'h0101, d1}) begin failures++; $display("FAIL autoinc_wr_words got=%h,%h", wr_q[0], wr_q[1]); end end
  endtask
`else
  task automatic test_no_autoinc();
    logic [31:0] rb;
    logic pre;
    logic [15:0] a, d;
    a = 16'($urandom);
    clear_mon();
    txn(OPC_READ, a, 32, 32'h0, rb, pre);
    checks++; if (rd_q.size() !== 1) begin failures++; $display("FAIL noinc_rd_count got=%0d exp=1", rd_q.size()); end
    checks++; if (rb !== {16'h0, mem[a]}) begin failures++; $display("FAIL noinc_miso got=%h exp=%h", rb, {16'h0, mem[a]}); end
    d = 16'($urandom);
    clear_mon();
    txn(OPC_WRITE, a, 32, {16'($urandom), d}, rb, pre);
    mem[a] = d;
    checks++; if (wr_q.size() !== 1) begin failures++; $display("FAIL noinc_wr_count got=%0d exp=1", wr_q.size()); end
    else begin checks++; if (wr_q[0] !== {a, d}) begin failures++; $display("FAIL noinc_wr_word got=%h exp=%h", wr_q[0], {a, d}); end end
  endtask
`endif

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    test_reset();
    test_read();
    test_write();
    test_bad_opcode();
    test_abort();
    test_random();
    test_reset_mid();
`ifdef SPI_RESP_AUTOINC_EN
    test_autoinc();
`else
    test_no_autoinc();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
